hc138_scan_driver: RTL
======================

Name: hc138_scan_driver

Overview:
- Upstream sequencer for the 3-to-8 active-low decoder stage (74HC138-style).
- Generates the 3-bit select address A2..A0 plus the decoder enables En/S1/S2N/S3N.
- Steps the address at a programmable rate in up, down, ping-pong or hold mode, for LED chasers and multiplexed seven-segment digit scanning on the lesson boards.
- All outputs are registered and connect directly to the decoder's same-named inputs.

Parameters:
- TICK_DIV, 25000000, clk cycles per address step; legal range 2..2^26-1; the prescaler width is derived from it.
- START_ADDR, 0, address loaded at reset, range 0..7.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  1 = prescaler advances and outputs are enabled; 0 = pause.
- blank  input  1  1 = force the decoder disabled (all Y*N high) without stopping the scan.
- mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
- A0  output  1  address bit 0 (LSB).
- A1  output  1  address bit 1.
- A2  output  1  address bit 2 (MSB).
- En  output  1  decoder global enable, active-high.
- S1  output  1  decoder enable, active-high.
- S2N  output  1  decoder enable, active-low.
- S3N  output  1  decoder enable, active-low.
- step  output  1  one-cycle pulse in the cycle the address register updates.
- wrap  output  1  one-cycle pulse, coincident with step, at a sequence boundary.

Behaviour:
- Decided interface facts: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge) takes priority over all other inputs, including mid-count and mid-sweep. After reset:
  - addr = START_ADDR, prescaler = 0, dir = up.
  - En = 0, S1 = 0, S2N = 1, S3N = 1.
  - step = 0, wrap = 0.
- Prescaler:
  - When run=1, counts 0..TICK_DIV-1 and wraps to 0.
  - tick = run & (prescaler == TICK_DIV-1).
  - When run=0, the prescaler holds its value; it is not cleared.
- Address update, registered: on a tick, addr is loaded in the same clk edge that wraps the prescaler.
  - Address-change latency is TICK_DIV cycles from run rising with prescaler=0.
  - step=1 in the cycle following that edge, i.e. together with the new address.
- Mode rules, evaluated on each tick:
  - 00 up: addr+1 mod 8; wrap when 7 -> 0.
  - 01 down: addr-1 mod 8; wrap when 0 -> 7.
  - 10 ping-pong, dir up: addr+1; at addr=6 -> 7, set dir=down and wrap=1.
  - 10 ping-pong, dir down: addr-1; at addr=1 -> 0, set dir=up and wrap=1.
  - 10 ping-pong sequence: 0,1,...,7,6,...,0,1,... (no repeated endpoints).
  - 11 hold: addr unchanged; step still pulses on the tick; wrap=0.
- dir is forced to up whenever mode != 10, so entering ping-pong always starts ascending.
  - Entering ping-pong at addr=7 with dir=up: the next tick goes 7 -> 6, sets dir=down and wrap=1 (turnaround).
- A mode change between ticks takes effect at the next tick. The prescaler is not reset by a mode change.
- Enable outputs are registered one cycle from run/blank:
  - active = run & ~blank.
  - active=1: En=1, S1=1, S2N=0, S3N=0.
  - otherwise: En=0, S1=0, S2N=1, S3N=1.
- blank=1 with run=1: address keeps scanning, step and wrap keep pulsing, decoder stays disabled.
- run=0: no ticks, address frozen, decoder disabled. Re-asserting run resumes from the held prescaler value.
- A0..A2 always present addr, including while disabled.

Test Plan:
1. TICK_DIV=4, mode=00, run=1 from reset: addr 0,1,...,7,0 changes every 4 cycles; first change 4 cycles after run; wrap=1 only with the 7 -> 0 step; En=1, S2N=0 from cycle 1.
2. mode=10, run=1: addr sequence 0..7,6..1,0,1; wrap pulses exactly at the 6 -> 7 and 1 -> 0 steps; no repeated 7 or 0.
3. mode=01 from START_ADDR=0: first step 0 -> 7 with wrap=1, then 6, 5, ...; switch to 11 at addr=5: addr stays 5, step keeps pulsing every 4 cycles, wrap=0.
4. Pause at prescaler=2, addr=3: run=0 for 10 cycles; addr and prescaler frozen, En=0, S1=0, S2N=1, S3N=1 one cycle later; run=1 again: next step to 4 occurs 2 cycles later.
5. blank=1 during up-count: En=0 one cycle later, addr continues 3 -> 4 -> 5, step and wrap unchanged; blank=0 re-enables the next cycle.
6. rst=1 asserted in ping-pong at addr=5, dir=down, prescaler=3: next edge gives addr=START_ADDR, prescaler=0, dir=up, all enables inactive, step=0; a simultaneous tick is ignored.

Source files
------------

// File: rtl/hc138_scan_driver_if.sv
// Control and decoder-side signal bundle for hc138_scan_driver.
// master drives run/blank/mode; slave (the driver) returns the decoder pins.
interface hc138_scan_driver_if;
    logic       run;
    logic       blank;
    logic [1:0] mode;
    logic       A0;
    logic       A1;
    logic       A2;
    logic       En;
    logic       S1;
    logic       S2N;
    logic       S3N;
    logic       step;
    logic       wrap;

    modport master (
        output run,
        output blank,
        output mode,
        input  A0,
        input  A1,
        input  A2,
        input  En,
        input  S1,
        input  S2N,
        input  S3N,
        input  step,
        input  wrap
    );

    modport slave (
        input  run,
        input  blank,
        input  mode,
        output A0,
        output A1,
        output A2,
        output En,
        output S1,
        output S2N,
        output S3N,
        output step,
        output wrap
    );
endinterface

// File: rtl/hc138_scan_driver.sv
// Address/enable sequencer for a 74HC138-style 3-to-8 decoder.
// Steps A2..A0 up, down, ping-pong or hold at a prescaled rate.
module hc138_scan_driver #(
    parameter int TICK_DIV   = 25000000,
    parameter int START_ADDR = 0
) (
    input logic clk,
    input logic rst,
    hc138_scan_driver_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0] ADDR0 = 3'(START_ADDR);

    typedef enum logic [1:0] {
        M_UP   = 2'b00,
        M_DN   = 2'b01,
        M_PP   = 2'b10,
        M_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    dir_e          dir_q;
    dir_e          dir_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [2:0]    addr_q;
    logic [2:0]    addr_d;
    logic          wrap_d;
    logic          step_q;
    logic          wrap_q;
    logic          act_q;
    logic          at_top;
    logic          tick;
    mode_e         mode;

    assign mode   = mode_e'(bus.mode);
    assign at_top = (pre_q == LAST);
    assign tick   = bus.run & at_top;

    // Prescaler only moves while running; a pause keeps its phase.
    always_comb begin
        pre_d = pre_q;
        if (bus.run) begin
            if (at_top) pre_d = '0;
            else        pre_d = pre_q + PW'(1);
        end
    end

    always_comb begin
        addr_d = addr_q;
        wrap_d = 1'b0;
        dir_d  = (mode == M_PP) ? dir_q : DIR_UP;
        if (tick) begin
            unique case (mode)
                M_UP: begin
                    addr_d = addr_q + 3'd1;
                    wrap_d = (addr_q == 3'd7);
                end
                M_DN: begin
                    addr_d = addr_q - 3'd1;
                    wrap_d = (addr_q == 3'd0);
                end
                M_PP: begin
                    if (dir_q == DIR_UP) begin
                        // Entering at 7 while ascending turns around at once.
                        if (addr_q == 3'd7) begin
                            addr_d = 3'd6;
                            dir_d  = DIR_DN;
                            wrap_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 3'd1;
                            if (addr_q == 3'd6) begin
                                dir_d  = DIR_DN;
                                wrap_d = 1'b1;
                            end
                        end
                    end else begin
                        if (addr_q == 3'd0) begin
                            addr_d = 3'd1;
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end else begin
                            addr_d = addr_q - 3'd1;
                            if (addr_q == 3'd1) begin
                                dir_d  = DIR_UP;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                end
                M_HOLD: begin
                    addr_d = addr_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            addr_q <= ADDR0;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            addr_q <= addr_d;
            dir_q  <= dir_d;
            step_q <= tick;
            wrap_q <= wrap_d;
            act_q  <= bus.run & ~bus.blank;
        end
    end

    assign bus.A0   = addr_q[0];
    assign bus.A1   = addr_q[1];
    assign bus.A2   = addr_q[2];
    assign bus.En   = act_q;
    assign bus.S1   = act_q;
    assign bus.S2N  = ~act_q;
    assign bus.S3N  = ~act_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;

endmodule
